// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the memory pin-bus arbiter.
//   state_t : arbiter FSM states (IDLE, ACCESS, RESP)
//   owner_t : requester encoding (OWN_CPU=0, OWN_DBG=1)
//   ADDR_W_DEF / DATA_W_DEF : default pin-bus widths
package cpu_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 7;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick.sv
// Two-input requester selector (round-robin or fixed debug priority).
//   cpu_req, dbg_req : pending requests
//   last_grant       : port granted most recently
//   grant_valid      : at least one request present
//   grant            : selected port
//   next_last_grant  : value last_grant should take if this grant is used
module rr_pick
  import cpu_bus_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic   cpu_req,
  input  logic   dbg_req,
  input  owner_t last_grant,
  output logic   grant_valid,
  output owner_t grant,
  output owner_t next_last_grant
);

  always_comb begin
    grant_valid = cpu_req | dbg_req;
    grant       = OWN_CPU;
    if (cpu_req && dbg_req) begin
      if (FIXED_PRIO != 0) begin
        grant = OWN_DBG;
      end else begin
        // Tie goes to whichever port was not served last.
        grant = (last_grant == OWN_CPU) ? OWN_DBG : OWN_CPU;
      end
    end else if (dbg_req) begin
      grant = OWN_DBG;
    end
    next_last_grant = grant_valid ? grant : last_grant;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the external memory pin bus between the CPU core and the
// debug/loader port. One access at a time, WAIT_STATES extra bus cycles per
// access, registered read data and a one-cycle ack to the granted port.
//   clk, reset                         : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata, cpu_rdata/ack : CPU requester port
//   dbg_req/we/addr/wdata, dbg_rdata/ack : debug requester port
//   bus_addr, bus_wdata, bus_we        : registered pin-bus outputs
//   bus_rdata                          : pin-bus read data
module mem_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned FIXED_PRIO  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we,
  input  logic [DATA_W-1:0] bus_rdata
);

  state_t     state, state_nx;
  logic [3:0] cnt;
  owner_t     owner;
  owner_t     last_grant;
  logic       pick_valid;
  owner_t     pick_grant;
  owner_t     pick_next_last;

  rr_pick #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_pick (
    .cpu_req        (cpu_req),
    .dbg_req        (dbg_req),
    .last_grant     (last_grant),
    .grant_valid    (pick_valid),
    .grant          (pick_grant),
    .next_last_grant(pick_next_last)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pick_valid) state_nx = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus outputs and acks are registered alongside the state so that no
  // combinational path exists from a req input to the pins or to ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= OWN_CPU;
      last_grant <= OWN_DBG;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_we     <= 1'b0;
      cpu_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      state   <= state_nx;
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            cnt        <= 4'(WAIT_STATES);
            owner      <= pick_grant;
            last_grant <= pick_next_last;
            if (pick_grant == OWN_DBG) begin
              bus_addr  <= dbg_addr;
              bus_wdata <= dbg_wdata;
              bus_we    <= dbg_we;
            end else begin
              bus_addr  <= cpu_addr;
              bus_wdata <= cpu_wdata;
              bus_we    <= cpu_we;
            end
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Last ACCESS cycle: strobe drops as RESP begins.
            bus_we <= 1'b0;
            if (owner == OWN_DBG) begin
              dbg_rdata <= bus_rdata;
              dbg_ack   <= 1'b1;
            end else begin
              cpu_rdata <= bus_rdata;
              cpu_ack   <= 1'b1;
            end
          end
        end
        default: begin
          bus_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter. Three instances share
// the stimulus: [0] WAIT_STATES=1 round-robin, [1] WAIT_STATES=1 fixed
// priority, [2] WAIT_STATES=0 round-robin. Each test resets all of them.
module tb_mem_bus_arbiter;

  logic       clk;
  logic       reset;
  logic       cpu_req, cpu_we, dbg_req, dbg_we;
  logic [6:0] cpu_addr, dbg_addr;
  logic [7:0] cpu_wdata, dbg_wdata, bus_rdata;

  logic [7:0] cpu_rdata [3];
  logic [7:0] dbg_rdata [3];
  logic       cpu_ack   [3];
  logic       dbg_ack   [3];
  logic [6:0] bus_addr  [3];
  logic [7:0] bus_wdata [3];
  logic       bus_we    [3];

  int n_checks = 0;
  int n_pass   = 0;

  mem_bus_arbiter #(.ADDR_W(7), .DATA_W(8), .WAIT_STATES(1), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata[0]), .cpu_ack(cpu_ack[0]),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata[0]), .dbg_ack(dbg_ack[0]),
    .bus_addr(bus_addr[0]), .bus_wdata(bus_wdata[0]), .bus_we(bus_we[0]),
    .bus_rdata(bus_rdata)
  );

  mem_bus_arbiter #(.ADDR_W(7), .DATA_W(8), .WAIT_STATES(1), .FIXED_PRIO(1)) u_fix (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata[1]), .cpu_ack(cpu_ack[1]),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata[1]), .dbg_ack(dbg_ack[1]),
    .bus_addr(bus_addr[1]), .bus_wdata(bus_wdata[1]), .bus_we(bus_we[1]),
    .bus_rdata(bus_rdata)
  );

  mem_bus_arbiter #(.ADDR_W(7), .DATA_W(8), .WAIT_STATES(0), .FIXED_PRIO(0)) u_ws0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata[2]), .cpu_ack(cpu_ack[2]),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata[2]), .dbg_ack(dbg_ack[2]),
    .bus_addr(bus_addr[2]), .bus_wdata(bus_wdata[2]), .bus_we(bus_we[2]),
    .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [1:0] exp_code [16];

  initial begin
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    bus_rdata = '0;

    // Reset values
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_bus_addr%0d", k), 32'(bus_addr[k]), 32'h0);
      check($sformatf("rst_bus_wdata%0d", k), 32'(bus_wdata[k]), 32'h0);
      check($sformatf("rst_bus_we%0d", k), 32'(bus_we[k]), 32'h0);
      check($sformatf("rst_acks%0d", k), 32'({dbg_ack[k], cpu_ack[k]}), 32'h0);
      check($sformatf("rst_rdata%0d", k), 32'({dbg_rdata[k], cpu_rdata[k]}), 32'h0);
    end

    // CPU read, WAIT_STATES=1
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h2A; bus_rdata = 8'h5C;
    tick();
    check("rd_addr0", 32'(bus_addr[0]), 32'h2A);
    check("rd_we0", 32'(bus_we[0]), 32'h0);
    check("rd_ack0", 32'(cpu_ack[0]), 32'h0);
    tick();
    check("rd_addr1", 32'(bus_addr[0]), 32'h2A);
    check("rd_ack1", 32'(cpu_ack[0]), 32'h0);
    tick();
    check("rd_ack2", 32'(cpu_ack[0]), 32'h1);
    check("rd_rdata2", 32'(cpu_rdata[0]), 32'h5C);
    check("rd_dbg_ack2", 32'(dbg_ack[0]), 32'h0);
    cpu_req = 1'b0;
    bus_rdata = 8'h00;
    tick();
    check("rd_ack3", 32'(cpu_ack[0]), 32'h0);
    check("rd_rdata_hold", 32'(cpu_rdata[0]), 32'h5C);
    check("rd_addr_hold", 32'(bus_addr[0]), 32'h2A);

    // Debug write
    do_reset();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 7'h7F; dbg_wdata = 8'hA5;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("wr_we%0d", i), 32'(bus_we[0]), (i < 2) ? 32'h1 : 32'h0);
      check($sformatf("wr_dack%0d", i), 32'(dbg_ack[0]), (i == 2) ? 32'h1 : 32'h0);
      check($sformatf("wr_cack%0d", i), 32'(cpu_ack[0]), 32'h0);
      if (i < 2) begin
        check($sformatf("wr_wdata%0d", i), 32'(bus_wdata[0]), 32'hA5);
        check($sformatf("wr_addr%0d", i), 32'(bus_addr[0]), 32'h7F);
      end
      if (i == 2) dbg_req = 1'b0;
    end

    // Simultaneous, round-robin: CPU, DBG, CPU, DBG every 4 cycles
    do_reset();
    cpu_we = 1'b0; cpu_addr = 7'h01;
    dbg_we = 1'b0; dbg_addr = 7'h02;
    bus_rdata = 8'h11;
    for (int i = 0; i < 16; i++) exp_code[i] = 2'b00;
    exp_code[2] = 2'b01; exp_code[6] = 2'b10; exp_code[10] = 2'b01; exp_code[14] = 2'b10;
    cpu_req = 1'b1; dbg_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("rr_ack%0d", i), 32'({dbg_ack[0], cpu_ack[0]}), 32'(exp_code[i]));
    end

    // Simultaneous, fixed priority: DBG until dbg_req drops, then CPU
    do_reset();
    for (int i = 0; i < 16; i++) exp_code[i] = 2'b00;
    exp_code[2] = 2'b10; exp_code[6] = 2'b10; exp_code[10] = 2'b10; exp_code[14] = 2'b01;
    cpu_req = 1'b1; dbg_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("fix_ack%0d", i), 32'({dbg_ack[1], cpu_ack[1]}), 32'(exp_code[i]));
      if (i == 10) dbg_req = 1'b0;
    end
    cpu_req = 1'b0;

    // Reset during the second ACCESS cycle of a write, then re-issue
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h33; cpu_wdata = 8'h77;
    tick();
    check("ab_we0", 32'(bus_we[0]), 32'h1);
    tick();
    check("ab_we1", 32'(bus_we[0]), 32'h1);
    reset = 1'b1;
    tick();
    check("ab_we_rst", 32'(bus_we[0]), 32'h0);
    check("ab_ack_rst", 32'(cpu_ack[0]), 32'h0);
    check("ab_addr_rst", 32'(bus_addr[0]), 32'h0);
    reset = 1'b0;
    tick();
    check("re_we0", 32'(bus_we[0]), 32'h1);
    check("re_addr0", 32'(bus_addr[0]), 32'h33);
    check("re_ack0", 32'(cpu_ack[0]), 32'h0);
    tick();
    check("re_we1", 32'(bus_we[0]), 32'h1);
    check("re_ack1", 32'(cpu_ack[0]), 32'h0);
    tick();
    check("re_ack2", 32'(cpu_ack[0]), 32'h1);
    check("re_we2", 32'(bus_we[0]), 32'h0);
    cpu_req = 1'b0;
    tick();
    check("re_ack3", 32'(cpu_ack[0]), 32'h0);

    // WAIT_STATES=0, address changed one cycle after grant
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h10; bus_rdata = 8'h3C;
    tick();
    check("ws0_addr0", 32'(bus_addr[2]), 32'h10);
    check("ws0_ack0", 32'(cpu_ack[2]), 32'h0);
    cpu_addr = 7'h11;
    tick();
    check("ws0_ack1", 32'(cpu_ack[2]), 32'h1);
    check("ws0_rdata1", 32'(cpu_rdata[2]), 32'h3C);
    check("ws0_addr1", 32'(bus_addr[2]), 32'h10);
    cpu_req = 1'b0;
    tick();
    check("ws0_ack2", 32'(cpu_ack[2]), 32'h0);
    check("ws0_addr2", 32'(bus_addr[2]), 32'h10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
